// File: rtl/nibble_pingpong_buf_if.sv
// Handshake and mux-facing signals of the nibble ping-pong buffer.
// The slave modport is the buffer itself; the master modport is the
// producer/consumer/mux side that drives requests and observes the slots.
interface nibble_pingpong_buf_if #(
  parameter int WIDTH = 4
);
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rd_ready;
  logic             rd_valid;
  logic             flush;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             s;
  logic [1:0]       count;

  modport slave (
    input  wr_valid, wr_data, rd_ready, flush,
    output wr_ready, rd_valid, in0, in1, s, count
  );

  modport master (
    output wr_valid, wr_data, rd_ready, flush,
    input  wr_ready, rd_valid, in0, in1, s, count
  );
endinterface

// File: rtl/nibble_pingpong_buf.sv
// Two-entry ping-pong buffer feeding a 4-bit 2:1 nibble mux. The two slot
// registers drive the mux data inputs and the read pointer drives its select,
// so the mux output is always the oldest unread nibble.
module nibble_pingpong_buf #(
  parameter int WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  nibble_pingpong_buf_if.slave bus
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic             wp_q, wp_d;
  logic             rp_q, rp_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  // Handshake status decoded from registered occupancy only, so wr_ready has
  // no combinational path from rd_ready (a full buffer never bypasses a write).
  assign bus.wr_ready = (count_q != 2'd2);
  assign bus.rd_valid = (count_q != 2'd0);

  assign push = bus.wr_valid && bus.wr_ready;
  assign pop  = bus.rd_ready && bus.rd_valid;

  // Next-state: flush wins over push/pop; otherwise push writes slot[wp],
  // pop advances rp, and occupancy tracks the net change.
  always_comb begin
    // NOTE: every signal gets a default first so no latch can be inferred.
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (bus.flush) begin
      slot0_d = '0;
      slot1_d = '0;
      wp_d    = 1'b0;
      rp_d    = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) begin
        if (wp_q) slot1_d = bus.wr_data;
        else      slot0_d = bus.wr_data;
        wp_d = ~wp_q;
      end
      if (pop) begin
        rp_d = ~rp_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State register with asynchronous clear of pointers, count and slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slots are reset too, because they drive the mux directly
      // and must read as zero after reset, not as power-up garbage.
      slot0_q <= '0;
      slot1_q <= '0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from
      // pre-edge values regardless of statement order.
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  assign bus.in0   = slot0_q;
  assign bus.in1   = slot1_q;
  assign bus.s     = rp_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_nibble_pingpong_buf.sv
// Directed bench for nibble_pingpong_buf. A behavioural 2:1 mux on the
// slot/select outputs stands in for the downstream nibble mux.
module tb_nibble_pingpong_buf;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  nibble_pingpong_buf_if #(.WIDTH(4)) bus ();

  nibble_pingpong_buf #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [3:0] mux_out;
  assign mux_out = bus.s ? bus.in1 : bus.in0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 4'h0;
    bus.rd_ready = 1'b0;
    bus.flush    = 1'b0;
    #12;
    check("rst_count", 8'(bus.count), 8'h0);
    check("rst_wr_ready", 8'(bus.wr_ready), 8'h1);
    check("rst_rd_valid", 8'(bus.rd_valid), 8'h0);
    check("rst_s", 8'(bus.s), 8'h0);
    rst_n = 1'b1;
    tick();

    // Fill and order: push 0xA then 0x5 with no consumer.
    bus.wr_valid = 1'b1;
    bus.wr_data  = 4'hA;
    tick();
    check("fill1_count", 8'(bus.count), 8'h1);
    check("fill1_rd_valid", 8'(bus.rd_valid), 8'h1);
    check("fill1_in0", 8'(bus.in0), 8'hA);
    bus.wr_data = 4'h5;
    tick();
    check("fill2_in0", 8'(bus.in0), 8'hA);
    check("fill2_in1", 8'(bus.in1), 8'h5);
    check("fill2_count", 8'(bus.count), 8'h2);
    check("fill2_wr_ready", 8'(bus.wr_ready), 8'h0);
    check("fill2_out", 8'(mux_out), 8'hA);
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    tick();
    check("pop1_s", 8'(bus.s), 8'h1);
    check("pop1_out", 8'(mux_out), 8'h5);
    check("pop1_count", 8'(bus.count), 8'h1);
    tick();
    check("pop2_count", 8'(bus.count), 8'h0);
    check("pop2_rd_valid", 8'(bus.rd_valid), 8'h0);
    check("pop2_s", 8'(bus.s), 8'h0);
    // Pop request on empty buffer is ignored.
    tick();
    check("empty_pop_s", 8'(bus.s), 8'h0);
    check("empty_pop_count", 8'(bus.count), 8'h0);
    bus.rd_ready = 1'b0;

    // Backpressure: fill with 1,2 then offer 3 while popping.
    bus.wr_valid = 1'b1;
    bus.wr_data  = 4'h1;
    tick();
    bus.wr_data = 4'h2;
    tick();
    check("bp_full_count", 8'(bus.count), 8'h2);
    bus.wr_data  = 4'h3;
    bus.rd_ready = 1'b1;
    tick();
    check("bp_reject_in0", 8'(bus.in0), 8'h1);
    check("bp_reject_count", 8'(bus.count), 8'h1);
    check("bp_reject_s", 8'(bus.s), 8'h1);
    check("bp_wr_ready", 8'(bus.wr_ready), 8'h1);
    bus.rd_ready = 1'b0;
    tick();
    check("bp_accept_in0", 8'(bus.in0), 8'h3);
    check("bp_accept_in1", 8'(bus.in1), 8'h2);
    check("bp_accept_count", 8'(bus.count), 8'h2);
    check("bp_accept_out", 8'(mux_out), 8'h2);

    // Flush while full, overriding a push of 0xE and a pop.
    bus.wr_data  = 4'hE;
    bus.rd_ready = 1'b1;
    bus.flush    = 1'b1;
    tick();
    check("flush_count", 8'(bus.count), 8'h0);
    check("flush_s", 8'(bus.s), 8'h0);
    check("flush_in0", 8'(bus.in0), 8'h0);
    check("flush_in1", 8'(bus.in1), 8'h0);
    check("flush_rd_valid", 8'(bus.rd_valid), 8'h0);
    bus.flush    = 1'b0;
    bus.rd_ready = 1'b0;

    // Simultaneous push/pop at count=1 with 0x7 in slot 0.
    bus.wr_data = 4'h7;
    tick();
    check("sim_pre_in0", 8'(bus.in0), 8'h7);
    check("sim_pre_count", 8'(bus.count), 8'h1);
    bus.wr_data  = 4'h9;
    bus.rd_ready = 1'b1;
    tick();
    check("sim_count", 8'(bus.count), 8'h1);
    check("sim_s", 8'(bus.s), 8'h1);
    check("sim_in1", 8'(bus.in1), 8'h9);
    check("sim_in0", 8'(bus.in0), 8'h7);
    check("sim_out", 8'(mux_out), 8'h9);
    bus.wr_valid = 1'b0;
    tick();
    check("sim_drain_count", 8'(bus.count), 8'h0);
    check("sim_drain_s", 8'(bus.s), 8'h0);

    // Wrap-around stream 0x0..0xF with the consumer always ready.
    for (int i = 0; i <= 16; i++) begin
      bus.wr_valid = (i < 16);
      bus.wr_data  = 4'(i);
      if (i > 0) begin
        check("wrap_rd_valid", 8'(bus.rd_valid), 8'h1);
        check("wrap_out", 8'(mux_out), 8'(i - 1));
        check("wrap_s", 8'(bus.s), 8'((i - 1) % 2));
      end
      tick();
    end
    bus.rd_ready = 1'b0;
    check("wrap_end_count", 8'(bus.count), 8'h0);

    // Asynchronous reset mid-stream at count=2.
    bus.wr_valid = 1'b1;
    bus.wr_data  = 4'hC;
    tick();
    bus.wr_data = 4'hD;
    tick();
    bus.wr_valid = 1'b0;
    check("pre_rst_count", 8'(bus.count), 8'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in0", 8'(bus.in0), 8'h0);
    check("arst_in1", 8'(bus.in1), 8'h0);
    check("arst_s", 8'(bus.s), 8'h0);
    check("arst_count", 8'(bus.count), 8'h0);
    check("arst_wr_ready", 8'(bus.wr_ready), 8'h1);
    check("arst_rd_valid", 8'(bus.rd_valid), 8'h0);
    #10;
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_pingpong_buf.md
Name: nibble_pingpong_buf

Overview:
Two-entry 4-bit ping-pong buffer that sits directly upstream of the 4-bit 2:1 nibble mux and feeds it. It captures nibbles from a producer over a valid/ready handshake into two slot registers, which drive the mux data inputs `in0` and `in1` directly. It also drives the mux select `s` from its read pointer, so the mux output always presents the oldest unread nibble. A downstream consumer pops entries with its own valid/ready handshake.

Parameters:
WIDTH, 4, data width of each slot; must match the mux data width (only 4 is supported).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
wr_valid  input  1  producer has a nibble on wr_data
wr_ready  output  1  buffer can accept a nibble this cycle
wr_data  input  4  nibble to store
rd_ready  input  1  consumer takes the nibble at the mux output this cycle
rd_valid  output  1  mux output holds a valid unread nibble
flush  input  1  synchronous clear of buffer state
in0  output  4  slot 0 contents; connects to the mux in0
in1  output  4  slot 1 contents; connects to the mux in1
s  output  1  read pointer; connects to the mux s (0 selects in0, 1 selects in1)
count  output  2  occupancy, 0..2

Behaviour:
- Reset (rst_n low, asynchronous): in0=0, in1=0, s=0, write pointer=0, count=0. This gives wr_ready=1 and rd_valid=0. Reset applies immediately mid-operation; any stored data is lost.
- State is count plus a 1-bit write pointer (wp) and a 1-bit read pointer (rp); s is rp, registered.
- wr_ready = (count != 2), decoded from registered state only; no combinational path from rd_ready.
- rd_valid = (count != 0), decoded from registered state only.
- Push: when wr_valid && wr_ready at a rising edge:
  - slot[wp] <= wr_data, wp toggles, count increments.
  - The other slot is unchanged.
- Pop: when rd_valid && rd_ready at a rising edge:
  - rp (and so s) toggles, count decrements.
  - Slot data is not cleared.
- Simultaneous push and pop with count=1: both occur and count stays 1.
  - The slot being popped is never the slot being written in that cycle.
- Full (count=2): wr_ready=0 even if a pop occurs in the same cycle (no write bypass). The write is accepted on the following cycle.
- Empty (count=0): rd_ready is ignored; rp does not move.
- wr_valid with wr_ready=0: ignored with no state change. The producer must hold wr_data.
- Latency: a nibble accepted at edge N is at the mux output (selected by s) after edge N, provided it is the oldest entry.
  - rd_valid rises in the cycle after acceptance; there is no same-cycle write-to-read bypass.
- Ordering: strict FIFO. Pointers wrap 1->0 naturally.
- flush (synchronous, active-high):
  - At the edge: count=0, wp=0, rp=0 (s=0), in0=0, in1=0.
  - It overrides any push or pop in the same cycle.
- Outputs in0, in1, s and count are direct register outputs.
- Unknowns: an X on wr_valid or rd_ready while the corresponding ready/valid is 1 is a bench error. The RTL need not guard against it.

Test Plan:
- Reset: assert rst_n=0 mid-stream with count=2 -> the same cycle shows in0=0, in1=0, s=0, count=0, wr_ready=1, rd_valid=0.
- Fill and order: push 0xA then 0x5 with rd_ready=0 ->
  - in0=0xA, in1=0x5, count=2, wr_ready=0.
  - With the mux attached, out=0xA.
  - Pop once -> s=1, out=0x5. Pop again -> count=0, rd_valid=0.
- Backpressure: with count=2, hold wr_valid=1 with wr_data=0x3 and pop at the same edge ->
  - The write is not accepted that cycle.
  - It is accepted the next cycle into the freed slot 0: in0=0x3.
- Simultaneous push/pop: with count=1 holding 0x7 in slot 0, push 0x9 and pop at the same edge -> count=1, s=1, in1=0x9, mux out=0x9.
- Wrap-around: stream 0x0..0xF continuously with rd_ready=1 -> the consumer sees 0x0..0xF in order and s alternates after each pop.
- Flush: with count=2, assert flush together with wr_valid=1 and rd_ready=1 -> after the edge count=0, s=0, in0=in1=0, and no write is stored.
